// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg
// Shared definitions for the P7 instruction-fetch sequencer: FSM state
// encoding, exception codes reported to IF/ID, default fetch addresses
// and the priority ranks used when merging redirect requests.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_t;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_IBE  = 5'd6;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] DEF_TEXT_LO    = 32'h0000_3000;
  localparam logic [31:0] DEF_TEXT_HI    = 32'h0000_4ffc;

  // Cycles a request may wait for imem_ack before an IBE fault.
  localparam logic [7:0] FETCH_TIMEOUT = 8'd16;

  // Redirect ranks; a larger value wins.
  localparam logic [1:0] PRI_NONE = 2'd0;
  localparam logic [1:0] PRI_BR   = 2'd1;
  localparam logic [1:0] PRI_ERET = 2'd2;
  localparam logic [1:0] PRI_EXC  = 2'd3;

endpackage

// File: rtl/fetch_redirect_arb.sv
// fetch_redirect_arb
// Combinational priority mux over the next-PC redirect sources:
// exception entry > eret > branch/jump.
// Ports:
//   i_exc_req, i_eret_req, i_br_req : redirect requests
//   i_epc, i_br_target              : eret / branch targets
//   o_redir_valid                   : some redirect requested this cycle
//   o_redir_pc                      : target of the winning request
//   o_redir_pri                     : rank of the winning request
module fetch_redirect_arb
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC
) (
  input  logic        i_exc_req,
  input  logic        i_eret_req,
  input  logic [31:0] i_epc,
  input  logic        i_br_req,
  input  logic [31:0] i_br_target,
  output logic        o_redir_valid,
  output logic [31:0] o_redir_pc,
  output logic [1:0]  o_redir_pri
);

  always_comb begin
    o_redir_valid = 1'b0;
    o_redir_pc    = 32'h0;
    o_redir_pri   = PRI_NONE;
    if (i_exc_req) begin
      o_redir_valid = 1'b1;
      o_redir_pc    = HANDLER_PC;
      o_redir_pri   = PRI_EXC;
    end else if (i_eret_req) begin
      o_redir_valid = 1'b1;
      o_redir_pc    = i_epc;
      o_redir_pri   = PRI_ERET;
    end else if (i_br_req) begin
      o_redir_valid = 1'b1;
      o_redir_pc    = i_br_target;
      o_redir_pri   = PRI_BR;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Instruction-fetch stage controller. Owns the fetch PC, issues one
// handshaked request at a time to instruction memory and presents a
// single tagged instruction (or an address fault) to the IF/ID register.
// Optional build macro: FETCH_TIMEOUT_EN adds an imem_ack wait limit
// that raises an IBE fault (exccode 6).
// Ports:
//   clk, reset (async, active-low)
//   stall                        : IF/ID cannot accept this cycle
//   exc_req, eret_req/epc, br_req/br_target : redirect sources
//   imem_req/imem_addr/imem_ack/imem_rdata  : instruction memory handshake
//   if_valid/if_instr/if_pc/if_exccode      : result to IF/ID
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC,
  parameter logic [31:0] TEXT_LO    = DEF_TEXT_LO,
  parameter logic [31:0] TEXT_HI    = DEF_TEXT_HI
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        br_req,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [4:0]  if_exccode
);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic         r_pending, w_pending_nxt;
  logic [31:0]  r_pend_pc, w_pend_pc_nxt;
  logic [1:0]   r_pend_pri, w_pend_pri_nxt;
  logic [31:0]  r_if_instr, w_if_instr_nxt;
  logic [31:0]  r_if_pc, w_if_pc_nxt;
  logic [4:0]   r_if_exccode, w_if_exccode_nxt;
`ifdef FETCH_TIMEOUT_EN
  logic [7:0]   r_wait, w_wait_nxt;
`endif

  logic         w_redir_valid;
  logic [31:0]  w_redir_pc;
  logic [1:0]   w_redir_pri;
  logic         w_new_wins;
  logic         w_take_valid;
  logic [31:0]  w_take_pc;
  logic [1:0]   w_take_pri;
  logic         w_fault;

  fetch_redirect_arb #(
    .HANDLER_PC (HANDLER_PC)
  ) u_arb (
    .i_exc_req     (exc_req),
    .i_eret_req    (eret_req),
    .i_epc         (epc),
    .i_br_req      (br_req),
    .i_br_target   (br_target),
    .o_redir_valid (w_redir_valid),
    .o_redir_pc    (w_redir_pc),
    .o_redir_pri   (w_redir_pri)
  );

  // A new redirect replaces a pending one only if it ranks strictly higher;
  // w_take_* is the redirect that would be honoured at this edge.
  assign w_new_wins   = w_redir_valid && (!r_pending || (w_redir_pri > r_pend_pri));
  assign w_take_valid = r_pending || w_redir_valid;
  assign w_take_pc    = w_new_wins ? w_redir_pc  : r_pend_pc;
  assign w_take_pri   = w_new_wins ? w_redir_pri : r_pend_pri;

  assign w_fault = (r_pc < TEXT_LO) || (r_pc > TEXT_HI) || (r_pc[1:0] != 2'b00);

  assign imem_req   = (r_state == ST_REQ);
  assign imem_addr  = r_pc;
  assign if_valid   = (r_state == ST_HOLD) || (r_state == ST_FAULT);
  assign if_instr   = r_if_instr;
  assign if_pc      = r_if_pc;
  assign if_exccode = r_if_exccode;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_pending    <= 1'b0;
      r_pend_pc    <= RESET_PC;
      r_pend_pri   <= PRI_NONE;
      r_if_instr   <= 32'h0;
      r_if_pc      <= RESET_PC;
      r_if_exccode <= EXC_NONE;
`ifdef FETCH_TIMEOUT_EN
      r_wait       <= 8'd0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_pending    <= w_pending_nxt;
      r_pend_pc    <= w_pend_pc_nxt;
      r_pend_pri   <= w_pend_pri_nxt;
      r_if_instr   <= w_if_instr_nxt;
      r_if_pc      <= w_if_pc_nxt;
      r_if_exccode <= w_if_exccode_nxt;
`ifdef FETCH_TIMEOUT_EN
      r_wait       <= w_wait_nxt;
`endif
    end
  end

  // A redirect seen in IDLE is taken immediately so it is not lost
  // before the next request is issued. Outside REQ the wait counter
  // is held at zero, so it restarts on every entry to REQ.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_pending_nxt    = r_pending;
    w_pend_pc_nxt    = r_pend_pc;
    w_pend_pri_nxt   = r_pend_pri;
    w_if_instr_nxt   = r_if_instr;
    w_if_pc_nxt      = r_if_pc;
    w_if_exccode_nxt = r_if_exccode;
`ifdef FETCH_TIMEOUT_EN
    w_wait_nxt       = 8'd0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_redir_valid) begin
          w_pc_nxt = w_redir_pc;
        end else if (w_fault) begin
          w_state_nxt      = ST_FAULT;
          w_if_instr_nxt   = 32'h0;
          w_if_pc_nxt      = r_pc;
          w_if_exccode_nxt = EXC_ADEL;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (imem_ack) begin
          if (w_take_valid) begin
            w_pc_nxt      = w_take_pc;
            w_pending_nxt = 1'b0;
            w_state_nxt   = ST_IDLE;
          end else begin
            w_if_instr_nxt   = imem_rdata;
            w_if_pc_nxt      = r_pc;
            w_if_exccode_nxt = EXC_NONE;
            w_pc_nxt         = r_pc + 32'd4;
            w_state_nxt      = ST_HOLD;
          end
`ifdef FETCH_TIMEOUT_EN
        end else if (r_wait == (FETCH_TIMEOUT - 8'd1)) begin
          if (w_take_valid) begin
            w_pc_nxt      = w_take_pc;
            w_pending_nxt = 1'b0;
            w_state_nxt   = ST_IDLE;
          end else begin
            w_if_instr_nxt   = 32'h0;
            w_if_pc_nxt      = r_pc;
            w_if_exccode_nxt = EXC_IBE;
            w_state_nxt      = ST_FAULT;
          end
`endif
        end else begin
`ifdef FETCH_TIMEOUT_EN
          w_wait_nxt = r_wait + 8'd1;
`endif
          if (w_take_valid) begin
            w_pending_nxt  = 1'b1;
            w_pend_pc_nxt  = w_take_pc;
            w_pend_pri_nxt = w_take_pri;
          end
        end
      end
      ST_HOLD: begin
        if (w_redir_valid) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = ST_IDLE;
        end else if (!stall) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (w_redir_valid) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
